ofifo: RTL and testbench
========================

# ofifo

Output FIFO between the systolic PE array and the SFU. Each of the `col` array columns drains its finished partial sums at its own cycle, so each column gets an independent lane FIFO. The block presents a full `col`-wide row only when every lane holds data. The SFU (or the PMEM write path in bypass mode) then pops that aligned row with a single read strobe.

## Interface
Parameters:
- `psum_bw`, 16, width of one partial sum.
- `col`, 8, number of lanes (array columns).
- `depth`, 16, entries per lane; must be a power of two and at least 2.

Ports:
- `clk`, input, 1: sole clock; all state updates on rising edge.
- `reset`, input, 1: synchronous, active-high; clears all state.
- `wr`, input, `col`: per-lane write strobe; bit i writes lane i.
- `in`, input, `psum_bw*col`: lane i data at `in[psum_bw*(i+1)-1 : psum_bw*i]`.
- `rd`, input, 1: pop one entry from every lane.
- `out`, output, `psum_bw*col`: head row, same lane packing as `in`.
- `o_valid`, output, 1: every lane non-empty; `out` is meaningful.
- `o_full`, output, 1: at least one lane is full.
- `o_ready`, output, 1: `~o_full`.
- `o_overflow`, output, 1: sticky flag; a write was dropped.

## Operation
- Each lane is a circular buffer with write pointer and read pointer of width log2(`depth`)+1. The extra MSB distinguishes full from empty.
- Lane empty: `wptr == rptr`. Lane full: the low bits are equal and the MSBs differ.
- Write to lane i is accepted when `wr[i]` is high and one of these holds:
  - lane i is not full, or
  - lane i is full and a pop is accepted this same cycle.
- On an accepted write, the entry is stored at `wptr`, then `wptr` increments.
- A write to a full lane with no accepted pop is dropped. It sets `o_overflow` to 1, and the flag is cleared only by `reset`.
- A pop is accepted only when `rd` and `o_valid` are both high. It increments every lane's `rptr` together.
- `rd` while `o_valid` is low is ignored: no pointer change and no error.
- `out` is first-word-fall-through: each lane slice shows the entry at that lane's `rptr`.
- The whole `out` bus is forced to 0 while `o_valid` is low, so stale lane contents never appear.
- Pointers wrap modulo 2×`depth`, which is natural binary overflow.
- Data passes through unmodified: no sign or width change, and no arithmetic.
- Flags are combinational from the current pointers: `o_valid`, `o_full`, `o_ready`.

## Timing
- Reset values:
  - all pointers 0;
  - `o_valid` = 0, `o_full` = 0, `o_ready` = 1, `o_overflow` = 0;
  - `out` = 0.
- Reset has priority over `wr` and `rd` in the same cycle. Reset mid-operation discards all contents; stored memory need not be cleared.
- Write-to-visible latency: data written at edge N is visible on `out` in the cycle after edge N. `o_valid` rises then if all other lanes are already non-empty.
- A pop at edge N advances `out` to the next row after edge N. If any lane becomes empty, `o_valid` drops in that cycle.
- Same lane, same cycle, write and pop:
  - lane not empty: occupancy is unchanged;
  - lane full: the write is accepted because of the pop, and no overflow occurs;
  - lane empty: no pop is possible, so only the write occurs.
- Sustained throughput is one row per cycle once all lanes are primed.
- `o_full` is a backpressure hint only. The block does not stall upstream; dropped writes are flagged through `o_overflow`.

## Structure
- Shared package holds:
  - the default `psum_bw`, `col` and `depth` constants;
  - a clog2-based pointer-width constant/function.
- The SFU and the PMEM path use the same `psum_bw`/`col` from the package.
- Natural sub-module: `ofifo_lane`, a single-lane FWFT FIFO.
  - Inputs: `clk`, `reset`, `wr`, `rd`, `in`.
  - Outputs: `out`, `empty`, `full`, `drop`.
  - The top instantiates `col` of them with a generate loop.
  - The top ANDs the `~empty` signals into `o_valid`, ORs the `full` signals into `o_full`, ORs `drop` into the sticky `o_overflow`, and broadcasts the accepted-pop signal to all lanes.

## Test plan
- Reset, then idle: `out` = 0, `o_valid` = 0, `o_ready` = 1, `o_overflow` = 0.
- Skewed fill:
  - Stimulus: lane i is written 16'h0100+i at cycle i, for i = 0..7.
  - Required: `o_valid` stays 0 until the cycle after the lane 7 write, then `out` = {16'h0107,…,16'h0100}.
  - After one `rd`: `o_valid` = 0 and `out` = 0.
- Full and overflow (`depth` = 16):
  - 16 writes to lane 0 only: `o_full` = 1, `o_ready` = 0.
  - 17th write: `o_overflow` = 1 and the lane 0 contents are unchanged.
- Concurrent write and pop on a full lane:
  - Stimulus: fill all lanes with 16 rows (values 0..15), then `rd` together with `wr` = 8'hFF carrying 16'h0010 each.
  - Required: `o_overflow` stays 0, `o_full` stays 1, and the heads read 1, then 2, … up to 16'h0010.
- Wrap-around: stream 100 rows at one write and one read per cycle. `out` sequence equals the input sequence with no gaps, and `o_valid` stays high after priming.
- Reset mid-stream:
  - Stimulus: with 5 rows stored, assert `reset` together with `wr`/`rd`.
  - Required: the next cycle shows `o_valid` = 0, `out` = 0 and `o_overflow` = 0.
  - A subsequent single full-row write appears intact.

Source files
------------

// File: rtl/ofifo_pkg.sv
// Shared sizing for the PE-array output path (ofifo, SFU, PMEM write path).
package ofifo_pkg;

    localparam int unsigned def_psum_bw = 16;
    localparam int unsigned def_col     = 8;
    localparam int unsigned def_depth   = 16;

    // Pointer width carries one extra MSB so full and empty are distinguishable.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ofifo_lane.sv
// Single-lane first-word-fall-through FIFO; one per array column.
module ofifo_lane
    import ofifo_pkg::*;
#(
    parameter int unsigned psum_bw = def_psum_bw,
    parameter int unsigned depth   = def_depth
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic               rd,
    input  logic [psum_bw-1:0] in,
    output logic [psum_bw-1:0] out,
    output logic               empty,
    output logic               full,
    output logic               drop
);

    localparam int unsigned pw = ptr_w(depth);
    localparam int unsigned aw = pw - 1;

    logic [pw-1:0]      wptr;
    logic [pw-1:0]      rptr;
    logic [psum_bw-1:0] mem [depth];
    logic               wr_ok;
    logic               rd_ok;

    assign empty = (wptr == rptr);
    assign full  = (wptr[aw-1:0] == rptr[aw-1:0]) && (wptr[aw] != rptr[aw]);
    assign rd_ok = rd && !empty;
    // A full lane still takes a write when the same-cycle pop frees a slot.
    assign wr_ok = wr && (!full || rd_ok);
    assign drop  = wr && full && !rd_ok;
    assign out   = mem[rptr[aw-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_ok) mem[wptr[aw-1:0]] <= in;
    end

endmodule

// File: rtl/ofifo.sv
// Output FIFO between PE array and SFU: independent lanes, row-aligned pop.
module ofifo
    import ofifo_pkg::*;
#(
    parameter int unsigned psum_bw = def_psum_bw,
    parameter int unsigned col     = def_col,
    parameter int unsigned depth   = def_depth
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col-1:0]         wr,
    input  logic [psum_bw*col-1:0] in,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_overflow
);

    logic [col-1:0]         lane_empty;
    logic [col-1:0]         lane_full;
    logic [col-1:0]         lane_drop;
    logic [psum_bw*col-1:0] lane_out;
    logic                   pop;

    assign o_valid = ~|lane_empty;
    assign o_full  = |lane_full;
    assign o_ready = ~o_full;
    assign pop     = rd & o_valid;
    assign out     = o_valid ? lane_out : '0;

    for (genvar i = 0; i < col; i++) begin : g_lane
        ofifo_lane #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .wr    (wr[i]),
            .rd    (pop),
            .in    (in[psum_bw*i +: psum_bw]),
            .out   (lane_out[psum_bw*i +: psum_bw]),
            .empty (lane_empty[i]),
            .full  (lane_full[i]),
            .drop  (lane_drop[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset)           o_overflow <= 1'b0;
        else if (|lane_drop) o_overflow <= 1'b1;
    end

endmodule

// File: tb/tb_ofifo.sv
// Scoreboard bench for ofifo: expected rows queued on write, compared on pop.
module tb_ofifo;

    localparam int unsigned BW = 16;
    localparam int unsigned NC = 8;
    localparam int unsigned W  = BW * NC;

    logic          clk = 1'b0;
    logic          reset;
    logic [NC-1:0] wr;
    logic [W-1:0]  din;
    logic          rd;
    logic [W-1:0]  out;
    logic          o_valid;
    logic          o_full;
    logic          o_ready;
    logic          o_overflow;

    int unsigned   total = 0;
    int unsigned   bad   = 0;
    logic [W-1:0]  q [$];
    logic [W-1:0]  r;

    ofifo #(
        .psum_bw (BW),
        .col     (NC),
        .depth   (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr         (wr),
        .in         (din),
        .rd         (rd),
        .out        (out),
        .o_valid    (o_valid),
        .o_full     (o_full),
        .o_ready    (o_ready),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] fill_row(input logic [BW-1:0] v);
        logic [W-1:0] x;
        for (int i = 0; i < NC; i++) x[BW*i +: BW] = v;
        return x;
    endfunction

    function automatic logic [W-1:0] rand_row();
        logic [W-1:0] x;
        for (int i = 0; i < NC; i++) x[BW*i +: BW] = BW'($urandom);
        return x;
    endfunction

    task automatic do_reset();
        reset = 1'b1; wr = '0; rd = 1'b0;
        tick();
        reset = 1'b0;
        q.delete();
    endtask

    initial begin
        reset = 1'b1; wr = '0; rd = 1'b0; din = '0;
        tick(); tick();
        reset = 1'b0;
        tick();

        // reset / idle
        chk("rst_out",   out,           '0);
        chk("rst_valid", W'(o_valid),   W'(0));
        chk("rst_ready", W'(o_ready),   W'(1));
        chk("rst_full",  W'(o_full),    W'(0));
        chk("rst_ovf",   W'(o_overflow), W'(0));

        // skewed fill: one lane per cycle
        r = '0;
        for (int i = 0; i < NC; i++) begin
            din = '0;
            din[BW*i +: BW] = BW'(16'h0100 + i);
            r[BW*i +: BW]   = BW'(16'h0100 + i);
            wr = NC'(1) << i;
            tick();
            wr = '0;
            if (i < NC - 1) chk("skew_valid_lo", W'(o_valid), W'(0));
        end
        q.push_back(r);
        chk("skew_valid_hi", W'(o_valid), W'(1));
        chk("skew_row", out, q.pop_front());
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("skew_after_valid", W'(o_valid), W'(0));
        chk("skew_after_out",   out,         '0);

        // full and overflow on lane 0
        do_reset();
        for (int k = 0; k < 16; k++) begin
            din = '0;
            din[BW-1:0] = BW'(16'h0A00 + k);
            wr = NC'(1);
            tick();
        end
        wr = '0;
        chk("full_flag",  W'(o_full),     W'(1));
        chk("full_ready", W'(o_ready),    W'(0));
        chk("full_ovf0",  W'(o_overflow), W'(0));
        din[BW-1:0] = 16'hDEAD;
        wr = NC'(1);
        tick();
        wr = '0;
        chk("ovf_set", W'(o_overflow), W'(1));
        for (int k = 0; k < 16; k++) begin
            din = fill_row(BW'(16'h0B00 + k));
            r = din;
            r[BW-1:0] = BW'(16'h0A00 + k);
            q.push_back(r);
            wr = NC'(8'hFE);
            tick();
            wr = '0;
            chk("ovf_lane0_row", out, q.pop_front());
            rd = 1'b1;
            tick();
            rd = 1'b0;
        end
        chk("ovf_drain_valid", W'(o_valid),    W'(0));
        chk("ovf_drain_full",  W'(o_full),     W'(0));
        chk("ovf_sticky",      W'(o_overflow), W'(1));

        // concurrent write + pop on full lanes
        do_reset();
        for (int k = 0; k < 16; k++) begin
            din = fill_row(BW'(k));
            q.push_back(din);
            wr = '1;
            tick();
        end
        wr = '0;
        chk("cw_full_pre", W'(o_full), W'(1));
        chk("cw_head0", out, q.pop_front());
        din = fill_row(16'h0010);
        q.push_back(din);
        wr = '1; rd = 1'b1;
        tick();
        wr = '0; rd = 1'b0;
        chk("cw_no_ovf",    W'(o_overflow), W'(0));
        chk("cw_full_post", W'(o_full),     W'(1));
        for (int k = 0; k < 16; k++) begin
            chk("cw_head", out, q.pop_front());
            rd = 1'b1;
            tick();
            rd = 1'b0;
        end
        chk("cw_empty_valid", W'(o_valid),  W'(0));
        chk("cw_queue_empty", W'(q.size()), W'(0));

        // wrap-around streaming, one write and one pop per cycle
        do_reset();
        for (int j = 0; j < 100; j++) begin
            din = rand_row();
            wr = '1;
            if (j > 0) begin
                chk("stream_valid", W'(o_valid), W'(1));
                chk("stream_row",   out,         q.pop_front());
                rd = 1'b1;
            end
            q.push_back(din);
            tick();
        end
        wr = '0;
        chk("stream_last", out, q.pop_front());
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("stream_end_valid", W'(o_valid), W'(0));

        // reset mid-stream
        do_reset();
        for (int j = 0; j < 5; j++) begin
            din = rand_row();
            q.push_back(din);
            wr = '1;
            tick();
        end
        for (int j = 0; j < 12; j++) begin
            din = rand_row();
            wr = NC'(1);
            tick();
        end
        wr = '0;
        chk("mid_ovf_pre", W'(o_overflow), W'(1));
        reset = 1'b1; wr = '1; rd = 1'b1; din = rand_row();
        tick();
        reset = 1'b0; wr = '0; rd = 1'b0;
        q.delete();
        chk("mid_valid", W'(o_valid),    W'(0));
        chk("mid_out",   out,            '0);
        chk("mid_ovf",   W'(o_overflow), W'(0));
        din = rand_row();
        q.push_back(din);
        wr = '1;
        tick();
        wr = '0;
        chk("post_valid", W'(o_valid), W'(1));
        chk("post_row",   out,         q.pop_front());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
